// File: rtl/dds_sweep.sv
// dds_sweep: sine/cosine DDS for the dual DAC with a stepped linear
// frequency-sweep sequencer and strobes for detector window alignment.
module dds_sweep #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 14,
    parameter int LUT_AW  = 10,
    parameter int DWELL_W = 24,
    parameter int STEP_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wen,
    input  logic [1:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_start_fword,
    input  logic [PHASE_W-1:0] cfg_step_fword,
    input  logic [STEP_W-1:0]  cfg_step_num,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [PHASE_W-1:0] cfg_pword,
    input  logic               start,
    input  logic               abort,
    output logic [OUT_W-1:0]   dac_sin,
    output logic [OUT_W-1:0]   dac_cos,
    output logic               rdy,
    output logic               busy,
    output logic               step_strobe,
    output logic               sweep_wrap,
    output logic               sweep_done,
    output logic [PHASE_W-1:0] fword_cur
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam int DEPTH = 2 ** LUT_AW;
    localparam real PI = 3.14159265358979323846;
    localparam real AMP = (2.0 ** (OUT_W - 1)) - 1.0;
    localparam logic [LUT_AW-1:0] QTR = LUT_AW'(2 ** (LUT_AW - 2));
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

    // Configuration registers
    logic [1:0]         mode_q;
    logic [PHASE_W-1:0] start_q;
    logic [PHASE_W-1:0] step_q;
    logic [STEP_W-1:0]  stepn_q;
    logic [DWELL_W-1:0] dwell_cfg_q;
    logic [PHASE_W-1:0] pword_q;

    // Sequencer state
    state_t             state_q, state_d;
    logic [PHASE_W-1:0] fword_q, fword_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [STEP_W-1:0]  sidx_q, sidx_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               busy_q, busy_d;
    logic               stb_q, stb_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;

    // Output pipeline
    logic               v1_q, v2_q, rdy_q;
    logic [LUT_AW-1:0]  idx1_q;
    logic [OUT_W-1:0]   sin2_q, cos2_q;
    logic [OUT_W-1:0]   dsin_q, dcos_q;

    logic [DWELL_W-1:0] dwell_ld;
    logic               sweep_w;
    logic [LUT_AW-1:0]  idx_w;
    logic [LUT_AW-1:0]  cidx_w;
    logic [OUT_W-1:0]   tab [DEPTH];

    // Full-period sine table, two's complement, built at elaboration
    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        localparam real ANG = 2.0 * PI * real'(g) / real'(DEPTH);
        localparam int  VAL = int'(AMP * $sin(ANG));
        assign tab[g] = OUT_W'(VAL);
    end

    assign dwell_ld = (dwell_cfg_q == '0) ? '0 : dwell_cfg_q - DWELL_W'(1);
    assign sweep_w  = (mode_q == 2'd1) || (mode_q == 2'd2);
    assign idx_w    = LUT_AW'((acc_q + pword_q) >> (PHASE_W - LUT_AW));
    assign cidx_w   = idx1_q + QTR;

    // Configuration capture, locked while a sweep is active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= '0;
            start_q     <= '0;
            step_q      <= '0;
            stepn_q     <= '0;
            dwell_cfg_q <= '0;
            pword_q     <= '0;
        end else if (cfg_wen && !busy_q) begin
            mode_q      <= cfg_mode;
            start_q     <= cfg_start_fword;
            step_q      <= cfg_step_fword;
            stepn_q     <= cfg_step_num;
            dwell_cfg_q <= cfg_dwell;
            pword_q     <= cfg_pword;
        end
    end

    // Sequencer next state: abort beats start, start beats sweep progress
    always_comb begin
        state_d = state_q;
        fword_d = fword_q;
        acc_d   = acc_q;
        sidx_d  = sidx_q;
        dwell_d = dwell_q;
        busy_d  = busy_q;
        stb_d   = 1'b0;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        if (state_q != IDLE) begin
            acc_d = acc_q + fword_q;
        end
        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else if (start) begin
            fword_d = start_q;
            acc_d   = '0;
            sidx_d  = '0;
            dwell_d = dwell_ld;
            state_d = sweep_w ? RUN : HOLD;
            busy_d  = sweep_w;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end else if (sidx_q < stepn_q) begin
                        fword_d = fword_q + step_q;
                        sidx_d  = sidx_q + STEP_W'(1);
                        stb_d   = 1'b1;
                        dwell_d = dwell_ld;
                    end else if (mode_q == 2'd2) begin
                        fword_d = start_q;
                        sidx_d  = '0;
                        wrap_d  = 1'b1;
                        dwell_d = dwell_ld;
                    end else begin
                        state_d = HOLD;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer and phase accumulator registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fword_q <= '0;
            acc_q   <= '0;
            sidx_q  <= '0;
            dwell_q <= '0;
            busy_q  <= 1'b0;
            stb_q   <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fword_q <= fword_d;
            acc_q   <= acc_d;
            sidx_q  <= sidx_d;
            dwell_q <= dwell_d;
            busy_q  <= busy_d;
            stb_q   <= stb_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    // Phase-to-amplitude pipeline: index, table read, offset-binary out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            rdy_q  <= 1'b0;
            idx1_q <= '0;
            sin2_q <= '0;
            cos2_q <= '0;
            dsin_q <= MID;
            dcos_q <= MID;
        end else if (abort) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            rdy_q  <= 1'b0;
            dsin_q <= MID;
            dcos_q <= MID;
        end else begin
            v1_q   <= (state_q != IDLE);
            idx1_q <= idx_w;
            v2_q   <= v1_q;
            sin2_q <= tab[idx1_q];
            cos2_q <= tab[cidx_w];
            rdy_q  <= v2_q;
            dsin_q <= v2_q ? {~sin2_q[OUT_W-1], sin2_q[OUT_W-2:0]} : MID;
            dcos_q <= v2_q ? {~cos2_q[OUT_W-1], cos2_q[OUT_W-2:0]} : MID;
        end
    end

    assign dac_sin     = dsin_q;
    assign dac_cos     = dcos_q;
    assign rdy         = rdy_q;
    assign busy        = busy_q;
    assign step_strobe = stb_q;
    assign sweep_wrap  = wrap_q;
    assign sweep_done  = done_q;
    assign fword_cur   = fword_q;

endmodule

// File: tb/tb_dds_sweep.sv
// tb_dds_sweep: directed checks of the DDS sweep generator covering
// reset, fixed tone, single/continuous sweeps, restart and abort.
module tb_dds_sweep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_wen = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic [31:0] cfg_start_fword = '0;
    logic [31:0] cfg_step_fword = '0;
    logic [15:0] cfg_step_num = '0;
    logic [23:0] cfg_dwell = '0;
    logic [31:0] cfg_pword = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [13:0] dac_sin, dac_cos;
    logic        rdy, busy, step_strobe, sweep_wrap, sweep_done;
    logic [31:0] fword_cur;

    int tests_run = 0;
    int tests_failed = 0;

    dds_sweep dut (
        .clk(clk), .rst(rst), .cfg_wen(cfg_wen), .cfg_mode(cfg_mode),
        .cfg_start_fword(cfg_start_fword), .cfg_step_fword(cfg_step_fword),
        .cfg_step_num(cfg_step_num), .cfg_dwell(cfg_dwell),
        .cfg_pword(cfg_pword), .start(start), .abort(abort),
        .dac_sin(dac_sin), .dac_cos(dac_cos), .rdy(rdy), .busy(busy),
        .step_strobe(step_strobe), .sweep_wrap(sweep_wrap),
        .sweep_done(sweep_done), .fword_cur(fword_cur)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] m, input logic [31:0] sf,
                             input logic [31:0] stp, input logic [15:0] n,
                             input logic [23:0] dw, input logic [31:0] pw);
        cfg_mode = m; cfg_start_fword = sf; cfg_step_fword = stp;
        cfg_step_num = n; cfg_dwell = dw; cfg_pword = pw;
        cfg_wen = 1'b1;
        tick();
        cfg_wen = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        tests_run++; if (dac_sin !== 14'd8192) begin tests_failed++; $display("FAIL rst_sin got %0d want 8192", dac_sin); end
        tests_run++; if (dac_cos !== 14'd8192) begin tests_failed++; $display("FAIL rst_cos got %0d want 8192", dac_cos); end
        tests_run++; if ({rdy, busy, step_strobe, sweep_wrap, sweep_done} !== 5'b0) begin tests_failed++; $display("FAIL rst_flags got %b want 00000", {rdy, busy, step_strobe, sweep_wrap, sweep_done}); end
        tests_run++; if (fword_cur !== 32'h0) begin tests_failed++; $display("FAIL rst_fword got %h want 0", fword_cur); end
        rst = 1'b0;
        tick();
        cfg_write(2'd0, 32'h4000_0000, 32'h0, 16'd0, 24'd0, 32'h0);
        pulse_start();
        repeat (5) tick();
        tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL pre_rst_rdy got %b want 1", rdy); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (dac_sin !== 14'd8192 || dac_cos !== 14'd8192) begin tests_failed++; $display("FAIL midrst_dac got %0d/%0d want 8192/8192", dac_sin, dac_cos); end
        tests_run++; if (rdy !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_rdy_busy got %b%b want 00", rdy, busy); end
        tests_run++; if (fword_cur !== 32'h0) begin tests_failed++; $display("FAIL midrst_fword got %h want 0", fword_cur); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fixed_tone();
        int sin_exp [4] = '{8192, 16383, 8192, 1};
        int cos_exp [4] = '{16383, 8192, 1, 8192};
        cfg_write(2'd0, 32'h4000_0000, 32'h0, 16'd0, 24'd0, 32'h0);
        pulse_start();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL tone_busy got %b want 0", busy); end
        tests_run++; if (fword_cur !== 32'h4000_0000) begin tests_failed++; $display("FAIL tone_fword got %h want 40000000", fword_cur); end
        tick();
        tick();
        tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL tone_rdy_early got %b want 0", rdy); end
        for (int n = 0; n < 8; n++) begin
            tick();
            tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL tone_rdy n=%0d got %b want 1", n, rdy); end
            tests_run++; if (dac_sin !== 14'(sin_exp[n % 4])) begin tests_failed++; $display("FAIL tone_sin n=%0d got %0d want %0d", n, dac_sin, sin_exp[n % 4]); end
            tests_run++; if (dac_cos !== 14'(cos_exp[n % 4])) begin tests_failed++; $display("FAIL tone_cos n=%0d got %0d want %0d", n, dac_cos, cos_exp[n % 4]); end
        end
    endtask

    task automatic test_single_sweep();
        logic [31:0] ef;
        cfg_write(2'd1, 32'h0100_0000, 32'h0010_0000, 16'd3, 24'd5, 32'h0);
        pulse_start();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ss_busy0 got %b want 1", busy); end
        for (int c = 1; c <= 22; c++) begin
            tick();
            ef = 32'h0100_0000 + 32'h0010_0000 * ((c < 5) ? 0 : (c < 10) ? 1 : (c < 15) ? 2 : 3);
            tests_run++; if (fword_cur !== ef) begin tests_failed++; $display("FAIL ss_fword c=%0d got %h want %h", c, fword_cur, ef); end
            tests_run++; if (step_strobe !== (c == 5 || c == 10 || c == 15)) begin tests_failed++; $display("FAIL ss_strobe c=%0d got %b", c, step_strobe); end
            tests_run++; if (sweep_done !== (c == 20)) begin tests_failed++; $display("FAIL ss_done c=%0d got %b", c, sweep_done); end
            tests_run++; if (busy !== (c < 20)) begin tests_failed++; $display("FAIL ss_busy c=%0d got %b", c, busy); end
            tests_run++; if (sweep_wrap !== 1'b0) begin tests_failed++; $display("FAIL ss_wrap c=%0d got %b want 0", c, sweep_wrap); end
        end
        tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL ss_tone_persists got %b want 1", rdy); end
    endtask

    task automatic test_cont_sweep();
        logic [31:0] ef;
        logic [31:0] wf [4] = '{32'h0000_0000, 32'hFFF0_0000, 32'h0010_0000, 32'h0000_0000};
        logic ws [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic ww [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        cfg_write(2'd2, 32'h0100_0000, 32'h0010_0000, 16'd3, 24'd5, 32'h0);
        pulse_start();
        for (int c = 1; c <= 25; c++) begin
            tick();
            ef = 32'h0100_0000 + 32'h0010_0000 * ((c < 5) ? 0 : (c < 10) ? 1 : (c < 15) ? 2 : (c < 20) ? 3 : (c < 25) ? 0 : 1);
            tests_run++; if (fword_cur !== ef) begin tests_failed++; $display("FAIL cs_fword c=%0d got %h want %h", c, fword_cur, ef); end
            tests_run++; if (step_strobe !== (c == 5 || c == 10 || c == 15 || c == 25)) begin tests_failed++; $display("FAIL cs_strobe c=%0d got %b", c, step_strobe); end
            tests_run++; if (sweep_wrap !== (c == 20)) begin tests_failed++; $display("FAIL cs_wrap c=%0d got %b", c, sweep_wrap); end
            tests_run++; if (sweep_done !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL cs_done_busy c=%0d got %b%b want 01", c, sweep_done, busy); end
        end
        pulse_abort();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL cs_abort_busy got %b want 0", busy); end
        cfg_write(2'd2, 32'h0010_0000, 32'hFFF0_0000, 16'd2, 24'd1, 32'h0);
        pulse_start();
        for (int c = 0; c < 4; c++) begin
            tick();
            tests_run++; if (fword_cur !== wf[c]) begin tests_failed++; $display("FAIL wrap_fword c=%0d got %h want %h", c, fword_cur, wf[c]); end
            tests_run++; if (step_strobe !== ws[c]) begin tests_failed++; $display("FAIL wrap_strobe c=%0d got %b want %b", c, step_strobe, ws[c]); end
            tests_run++; if (sweep_wrap !== ww[c]) begin tests_failed++; $display("FAIL wrap_flag c=%0d got %b want %b", c, sweep_wrap, ww[c]); end
        end
        pulse_abort();
    endtask

    task automatic test_dwell_zero();
        cfg_write(2'd1, 32'h0050_0000, 32'h0000_0001, 16'd0, 24'd0, 32'h0);
        pulse_start();
        tests_run++; if (busy !== 1'b1 || sweep_done !== 1'b0) begin tests_failed++; $display("FAIL d0_entry got busy=%b done=%b want 1/0", busy, sweep_done); end
        cfg_mode = 2'd2; cfg_start_fword = 32'hABCD_0000; cfg_dwell = 24'd7; cfg_step_num = 16'd9;
        cfg_wen = 1'b1;
        tick();
        cfg_wen = 1'b0;
        tests_run++; if (sweep_done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL d0_done got done=%b busy=%b want 1/0", sweep_done, busy); end
        tests_run++; if (fword_cur !== 32'h0050_0000) begin tests_failed++; $display("FAIL d0_fword got %h want 00500000", fword_cur); end
        tick();
        tests_run++; if (sweep_done !== 1'b0) begin tests_failed++; $display("FAIL d0_done_pulse got %b want 0", sweep_done); end
        pulse_start();
        tests_run++; if (fword_cur !== 32'h0050_0000 || busy !== 1'b1) begin tests_failed++; $display("FAIL d0_cfg_locked got %h busy=%b want 00500000/1", fword_cur, busy); end
        tick();
        tests_run++; if (sweep_done !== 1'b1) begin tests_failed++; $display("FAIL d0_redone got %b want 1", sweep_done); end
    endtask

    task automatic test_restart();
        cfg_write(2'd1, 32'h0100_0000, 32'h0010_0000, 16'd3, 24'd5, 32'h0);
        pulse_start();
        repeat (7) tick();
        tests_run++; if (fword_cur !== 32'h0110_0000) begin tests_failed++; $display("FAIL rs_pre got %h want 01100000", fword_cur); end
        pulse_start();
        tests_run++; if (fword_cur !== 32'h0100_0000 || busy !== 1'b1) begin tests_failed++; $display("FAIL rs_reload got %h busy=%b want 01000000/1", fword_cur, busy); end
        for (int c = 1; c <= 5; c++) begin
            tick();
            tests_run++; if (step_strobe !== (c == 5)) begin tests_failed++; $display("FAIL rs_strobe c=%0d got %b", c, step_strobe); end
        end
        tests_run++; if (fword_cur !== 32'h0110_0000) begin tests_failed++; $display("FAIL rs_step got %h want 01100000", fword_cur); end
    endtask

    task automatic test_abort_conflict();
        pulse_abort();
        cfg_write(2'd1, 32'h4000_0000, 32'h0, 16'd1, 24'd100, 32'h0);
        pulse_start();
        repeat (6) tick();
        tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL ab_run_rdy got %b want 1", rdy); end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tests_run++; if (rdy !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL ab_rdy_busy got %b%b want 00", rdy, busy); end
        tests_run++; if (dac_sin !== 14'd8192 || dac_cos !== 14'd8192) begin tests_failed++; $display("FAIL ab_dac got %0d/%0d want 8192/8192", dac_sin, dac_cos); end
        repeat (4) tick();
        tests_run++; if (rdy !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL ab_idle got %b%b want 00", rdy, busy); end
        pulse_start();
        tests_run++; if (fword_cur !== 32'h4000_0000 || busy !== 1'b1) begin tests_failed++; $display("FAIL ab_restart got %h busy=%b want 40000000/1", fword_cur, busy); end
        tick();
        tick();
        tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL ab_rdy_early got %b want 0", rdy); end
        tick();
        tests_run++; if (rdy !== 1'b1 || dac_sin !== 14'd8192 || dac_cos !== 14'd16383) begin tests_failed++; $display("FAIL ab_s0 got rdy=%b %0d/%0d want 1 8192/16383", rdy, dac_sin, dac_cos); end
        tick();
        tests_run++; if (dac_sin !== 14'd16383 || dac_cos !== 14'd8192) begin tests_failed++; $display("FAIL ab_s1 got %0d/%0d want 16383/8192", dac_sin, dac_cos); end
    endtask

    initial begin
        test_reset();
        test_fixed_tone();
        test_single_sweep();
        test_cont_sweep();
        test_dwell_zero();
        test_restart();
        test_abort_conflict();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dds_sweep.md
Name: dds_sweep

Overview:
Parametrised DDS tone generator with a built-in linear frequency-sweep sequencer for the frequency-response measurement path. It produces sine and cosine samples in offset-binary format for the dual DAC. It generalises the fixed-word DDS with the following additions:
- configurable phase, output and LUT widths
- programmable phase offset
- single or continuous stepped sweeps with per-step dwell
- strobes that let the detector align its capture windows to each frequency step

Parameters:
PHASE_W, 32, phase accumulator / frequency-word width
OUT_W, 14, DAC sample width
LUT_AW, 10, sine table address width (table depth 2^LUT_AW)
DWELL_W, 24, dwell counter width
STEP_W, 16, step counter width

Ports:
clk  in  1  sample clock; all logic on rising edge
rst  in  1  asynchronous reset, active-high
cfg_wen  in  1  load configuration fields below
cfg_mode  in  2  0=fixed tone, 1=single sweep, 2=continuous sweep, 3=reserved (treated as 0)
cfg_start_fword  in  PHASE_W  first/fixed frequency word
cfg_step_fword  in  PHASE_W  per-step increment (mod 2^PHASE_W)
cfg_step_num  in  STEP_W  number of increments per sweep
cfg_dwell  in  DWELL_W  cycles per step (0 treated as 1)
cfg_pword  in  PHASE_W  phase offset applied to both outputs
start  in  1  start/restart pulse
abort  in  1  stop pulse
dac_sin  out  OUT_W  offset-binary sine
dac_cos  out  OUT_W  offset-binary cosine
rdy  out  1  dac outputs valid
busy  out  1  sweep sequencer active
step_strobe  out  1  1-cycle pulse on each frequency change
sweep_wrap  out  1  1-cycle pulse when continuous sweep reloads start word
sweep_done  out  1  1-cycle pulse at end of single sweep
fword_cur  out  PHASE_W  frequency word currently applied

Behaviour:
- Reset state:
  - state IDLE
  - all config regs, accumulator and fword_cur = 0
  - dac_sin = dac_cos = 2^(OUT_W-1) (midscale)
  - rdy, busy and all strobes = 0
- Configuration:
  - cfg_wen is accepted only when busy=0. It is ignored while busy.
  - Config registers are used only at start and during the sweep.
- States: IDLE, RUN, HOLD.
  - IDLE:
    - start → RUN
    - fword_cur <= cfg_start_fword (registered copy)
    - accumulator <= 0, step_idx <= 0, dwell_cnt <= max(dwell,1)-1
    - busy <= 1, except mode 0, which goes to HOLD with busy=0
  - RUN:
    - dwell_cnt decrements each cycle.
    - At dwell_cnt=0 with step_idx<step_num: fword_cur += step_fword (wraps), step_idx++, step_strobe=1 for one cycle, dwell reloads.
    - At dwell_cnt=0 with step_idx=step_num:
      - mode 1: HOLD, sweep_done=1 for one cycle, busy <= 0, fword_cur held.
      - mode 2: fword_cur <= start word, step_idx <= 0, sweep_wrap=1 for one cycle, dwell reloads.
    - step_num=0 in mode 1: done after one dwell. In mode 2: wrap every dwell.
  - HOLD: tone continues at fword_cur; start restarts as from IDLE.
- Control conflicts:
  - start in RUN restarts immediately.
  - abort in any state → IDLE, and outputs return to midscale as rdy drops.
  - Simultaneous start and abort: abort wins.
- Datapath:
  - acc <= acc + fword_cur every cycle in RUN/HOLD, mod 2^PHASE_W.
  - idx = top LUT_AW bits of (acc + pword).
  - sin = round((2^(OUT_W-1)-1)·sin(2π·idx/2^LUT_AW)), two's complement.
  - cos uses idx + 2^(LUT_AW-2).
  - Output = value + 2^(OUT_W-1), i.e. MSB inverted.
- Latency:
  - The first sample (acc=0) appears on dac outputs 3 edges after the edge sampling start. rdy rises on that same edge.
  - Sample n reflects acc = Σ fword_cur over the preceding n cycles.
  - A new fword_cur affects the output 3 cycles after step_strobe.
  - abort: rdy=0 and midscale outputs on the next edge.

Test Plan:
1. Reset: assert rst mid-tone → immediately dac_sin=dac_cos=8192, rdy=0, busy=0, fword_cur=0.
2. Mode 0, start_fword=2^30, pword=0 → sin sequence 8192,16383,8192,1 repeating; cos 16383,8192,1,8192. rdy high 3 edges after start.
3. Mode 1, start=0x01000000, step=0x00100000, step_num=3, dwell=5 → step_strobe at 5,10,15 cycles after the RUN entry edge, with fword_cur 0x01100000/0x01200000/0x01300000. sweep_done at cycle 20, busy low, tone persists.
4. Mode 2 same config, plus step=0xFFF00000 wrap check → after step 3 and dwell: sweep_wrap pulse, fword_cur=start. Step addition wraps mod 2^32 without flagging.
5. dwell=0, step_num=0, mode 1 → sweep_done exactly 1 cycle after RUN entry. cfg_wen while busy leaves config unchanged.
6. start and abort in the same cycle during RUN → IDLE, rdy=0, outputs 8192 next edge. A later start alone restarts from start_fword with acc=0.
